// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule types and constants.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned SHA256_ROUNDS = 64;
    localparam int unsigned SCHED_WINDOW  = 16;
    localparam int unsigned T_W           = $clog2(SHA256_ROUNDS);
    localparam logic [T_W-1:0] LAST_T     = T_W'(SHA256_ROUNDS - 1);

    // Small-sigma rotation and shift amounts
    localparam int unsigned S0_R1 = 7;
    localparam int unsigned S0_R2 = 18;
    localparam int unsigned S0_SH = 3;
    localparam int unsigned S1_R1 = 17;
    localparam int unsigned S1_R2 = 19;
    localparam int unsigned S1_SH = 10;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } sched_state_e;

endpackage

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma: rotr(R1) ^ rotr(R2) ^ shr(SH). Purely combinational.
module sha256_small_sigma
    import sha256_pkg::*;
#(
    parameter int unsigned R1 = 7,
    parameter int unsigned R2 = 18,
    parameter int unsigned SH = 3
) (
    input  logic [31:0] i_x,
    output logic [31:0] o_y
);

    word_t w_rot1;
    word_t w_rot2;
    word_t w_shr;

    // Fixed rotations and shift are just wiring
    always_comb begin
        w_rot1 = (i_x >> R1) | (i_x << (32 - R1));
        w_rot2 = (i_x >> R2) | (i_x << (32 - R2));
        w_shr  = i_x >> SH;
        o_y    = w_rot1 ^ w_rot2 ^ w_shr;
    end

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander: takes one 512-bit block and streams W[0..63].
// Optional feature: define SCHED_IDX_OUT_EN to expose the word index on o_w_idx.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_blk_valid,
    output logic         o_blk_ready,
    input  logic [511:0] i_blk_data,
    output logic         o_w_valid,
    input  logic         i_w_ready,
    output logic [31:0]  o_w_data,
    output logic         o_w_last
`ifdef SCHED_IDX_OUT_EN
    ,
    output logic [5:0]   o_w_idx
`endif
);

    sched_state_e   r_state;
    sched_state_e   w_state_next;
    word_t          r_window [SCHED_WINDOW];
    logic [T_W-1:0] r_t;

    word_t w_sigma0;
    word_t w_sigma1;
    word_t w_new_word;
    logic  w_blk_accept;
    logic  w_w_xfer;

    sha256_small_sigma #(
        .R1 (S0_R1),
        .R2 (S0_R2),
        .SH (S0_SH)
    ) u_sigma0 (
        .i_x (r_window[1]),
        .o_y (w_sigma0)
    );

    sha256_small_sigma #(
        .R1 (S1_R1),
        .R2 (S1_R2),
        .SH (S1_SH)
    ) u_sigma1 (
        .i_x (r_window[14]),
        .o_y (w_sigma1)
    );

    // Handshakes, outputs and next-state decode; outputs depend on state/registers only
    always_comb begin
        w_state_next = r_state;
        o_blk_ready  = (r_state == StIdle);
        o_w_valid    = (r_state == StRun);
        o_w_data     = r_window[0];
        o_w_last     = (r_state == StRun) && (r_t == LAST_T);
        w_blk_accept = i_blk_valid && o_blk_ready;
        w_w_xfer     = o_w_valid && i_w_ready;
        // Single-cycle expansion: sigma1(W[t+14]) + W[t+9] + sigma0(W[t+1]) + W[t]
        w_new_word   = w_sigma1 + r_window[9] + w_sigma0 + r_window[0];
        unique case (r_state)
            StIdle: if (w_blk_accept) w_state_next = StRun;
            StRun:  if (w_w_xfer && (r_t == LAST_T)) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Window shift register: load on accept, shift in the new word on each transfer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < SCHED_WINDOW; k++) begin
                r_window[k] <= '0;
            end
        end else if (w_blk_accept) begin
            for (int k = 0; k < SCHED_WINDOW; k++) begin
                r_window[k] <= i_blk_data[511 - 32*k -: 32];
            end
        end else if (w_w_xfer) begin
            for (int k = 0; k < SCHED_WINDOW - 1; k++) begin
                r_window[k] <= r_window[k+1];
            end
            r_window[SCHED_WINDOW-1] <= w_new_word;
        end
    end

    // Word index counter; wraps to 0 after the last word, which is harmless
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_t <= '0;
        end else if (w_blk_accept) begin
            r_t <= '0;
        end else if (w_w_xfer) begin
            r_t <= r_t + T_W'(1);
        end
    end

`ifdef SCHED_IDX_OUT_EN
    assign o_w_idx = r_t;
`endif

endmodule
